// File: rtl/run_ctrl_pkg.sv
// rtl/run_ctrl_pkg.sv - shared state encoding and parameter defaults for run_controller
package run_ctrl_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_DRAIN   = 3'd2,
    ST_HALTED  = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  localparam int DEF_RESET_CYCLES = 1;
  localparam int DEF_MAX_CYCLES   = 100000;
  localparam int DEF_DRAIN_CYCLES = 4;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] q
);

  // count up on enable, stick at all-ones instead of wrapping
  always_ff @(posedge clock) begin
    if (reset || clr) begin
      q <= '0;
    end else if (en && (q != '1)) begin
      q <= q + 1'b1;
    end
  end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - core reset sequencing, run accounting, halt drain and watchdog
module run_controller
  import run_ctrl_pkg::*;
#(
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int MAX_CYCLES   = DEF_MAX_CYCLES,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
  parameter int CNT_W        = 32
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               halt_req,
  input  logic               retire,
  output logic               core_reset,
  output logic               run,
  output logic               done,
  output logic               timeout,
  output logic [CNT_W-1:0]   cycle_count,
  output logic [CNT_W-1:0]   retire_count,
  output logic [STATE_W-1:0] state
);

  localparam int HOLD_W  = $clog2(RESET_CYCLES + 1);
  localparam int DRAIN_W = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES);
  // watchdog compare is done at >= 32 bits so a narrow, saturated cycle
  // counter can never alias onto a large MAX_CYCLES value
  localparam int CMP_W   = (CNT_W > 32) ? CNT_W : 32;

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);
  localparam logic [CMP_W-1:0]   WATCH_LAST = CMP_W'(MAX_CYCLES - 1);

  state_t             st, st_nxt;
  logic [HOLD_W-1:0]  hold_cnt, hold_nxt;
  logic [DRAIN_W-1:0] drain_cnt, drain_nxt;
  logic               counting;
  logic               count_clr;
  logic [CMP_W-1:0]   cycle_ext;

  assign cycle_ext = CMP_W'(cycle_count);
  assign counting  = (st == ST_RUN) || (st == ST_DRAIN);
  assign count_clr = (st == ST_HOLD);
  assign state     = st;

  // next-state logic plus hold and drain counter updates
  always_comb begin
    st_nxt    = st;
    hold_nxt  = hold_cnt;
    drain_nxt = drain_cnt;
    case (st)
      ST_HOLD: begin
        if (hold_cnt == HOLD_LAST) begin
          st_nxt   = ST_RUN;
          hold_nxt = '0;
        end else begin
          hold_nxt = hold_cnt + 1'b1;
        end
      end
      ST_RUN: begin
        // a halt in the same cycle as the watchdog limit takes priority
        if (halt_req) begin
          st_nxt    = (DRAIN_CYCLES == 0) ? ST_HALTED : ST_DRAIN;
          drain_nxt = '0;
        end else if (cycle_ext == WATCH_LAST) begin
          st_nxt = ST_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        if (drain_cnt == DRAIN_LAST) begin
          st_nxt = ST_HALTED;
        end else begin
          drain_nxt = drain_cnt + 1'b1;
        end
      end
      default: st_nxt = st;
    endcase
  end

  // state register and registered status outputs decoded from the next state
  always_ff @(posedge clock) begin
    if (reset) begin
      st         <= ST_HOLD;
      hold_cnt   <= '0;
      drain_cnt  <= '0;
      core_reset <= 1'b1;
      run        <= 1'b0;
      done       <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      st         <= st_nxt;
      hold_cnt   <= hold_nxt;
      drain_cnt  <= drain_nxt;
      core_reset <= (st_nxt == ST_HOLD);
      run        <= (st_nxt == ST_RUN) || (st_nxt == ST_DRAIN);
      done       <= (st_nxt == ST_HALTED) || (st_nxt == ST_TIMEOUT);
      timeout    <= (st_nxt == ST_TIMEOUT);
    end
  end

  sat_counter #(.W(CNT_W)) u_cycles (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .en    (counting),
    .q     (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_retires (
    .clock (clock),
    .reset (reset),
    .clr   (count_clr),
    .en    (counting && retire),
    .q     (retire_count)
  );

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - self-checking bench for run_controller
module tb_run_controller;

  localparam int A_RC  = 3;
  localparam int A_MAX = 50;
  localparam int A_DR  = 4;
  localparam longint A_SAT = 64'h0000_0000_FFFF_FFFF;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic a_reset = 1'b1, a_halt = 1'b0, a_retire = 1'b0;
  logic b_reset = 1'b1, b_halt = 1'b0, b_retire = 1'b0;
  logic c_reset = 1'b1, c_halt = 1'b0, c_retire = 1'b0;
  logic a_cr, a_run, a_done, a_to, b_cr, b_run, b_done, b_to, c_cr, c_run, c_done, c_to;
  logic [31:0] a_cyc, a_ret, b_cyc, b_ret;
  logic [3:0]  c_cyc, c_ret;
  logic [2:0]  a_state, b_state, c_state;

  run_controller #(.RESET_CYCLES(A_RC), .MAX_CYCLES(A_MAX), .DRAIN_CYCLES(A_DR), .CNT_W(32)) dut_a (
    .clock(clock), .reset(a_reset), .halt_req(a_halt), .retire(a_retire), .core_reset(a_cr),
    .run(a_run), .done(a_done), .timeout(a_to), .cycle_count(a_cyc), .retire_count(a_ret), .state(a_state));

  run_controller #(.RESET_CYCLES(1), .MAX_CYCLES(50), .DRAIN_CYCLES(0), .CNT_W(32)) dut_b (
    .clock(clock), .reset(b_reset), .halt_req(b_halt), .retire(b_retire), .core_reset(b_cr),
    .run(b_run), .done(b_done), .timeout(b_to), .cycle_count(b_cyc), .retire_count(b_ret), .state(b_state));

  run_controller #(.RESET_CYCLES(2), .MAX_CYCLES(100000), .DRAIN_CYCLES(4), .CNT_W(4)) dut_c (
    .clock(clock), .reset(c_reset), .halt_req(c_halt), .retire(c_retire), .core_reset(c_cr),
    .run(c_run), .done(c_done), .timeout(c_to), .cycle_count(c_cyc), .retire_count(c_ret), .state(c_state));

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic   rst;
    logic   halt;
    logic   ret;
    int     st;
    longint cyc;
    longint rcnt;
  } vec_t;

  vec_t tbl[9];

  // behavioural model of dut_a: visible state derived from elapsed cycles
  int     m_age;
  int     m_halt;
  longint m_cyc, m_ret;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [79:0] got, input logic [79:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, want);
    end
  endtask

  function automatic logic [79:0] expect_of(input int st, input longint cyc, input longint rc);
    logic [31:0] c32, r32;
    c32 = cyc[31:0];
    r32 = rc[31:0];
    return {9'd0, 3'(st), st == 0, (st == 1) || (st == 2), (st == 3) || (st == 4), st == 4, c32, r32};
  endfunction

  function automatic logic [79:0] obs(input int which);
    case (which)
      0:       return {9'd0, a_state, a_cr, a_run, a_done, a_to, a_cyc, a_ret};
      1:       return {9'd0, b_state, b_cr, b_run, b_done, b_to, b_cyc, b_ret};
      default: return {9'd0, c_state, c_cr, c_run, c_done, c_to, 28'd0, c_cyc, 28'd0, c_ret};
    endcase
  endfunction

  function automatic int m_state();
    int a;
    if (m_age < A_RC) return 0;
    a = m_age - A_RC;
    if (m_halt >= 0) begin
      if (a <= m_halt) return 1;
      if (a <= m_halt + A_DR) return 2;
      return 3;
    end
    if (a >= A_MAX) return 4;
    return 1;
  endfunction

  task automatic model_step(input logic rst, input logic halt, input logic ret);
    int s;
    s = m_state();
    if (rst) begin
      m_age = 0; m_halt = -1; m_cyc = 0; m_ret = 0;
    end else begin
      if (s == 1 || s == 2) begin
        if (m_cyc < A_SAT) m_cyc++;
        if (ret && m_ret < A_SAT) m_ret++;
      end
      if (s == 1 && halt) m_halt = m_age - A_RC;
      m_age++;
    end
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < 9; i++) begin
      a_reset = tbl[i].rst; a_halt = tbl[i].halt; a_retire = tbl[i].ret;
      tick();
      chk($sformatf("%s_row%0d", tag, i), obs(0), expect_of(tbl[i].st, tbl[i].cyc, tbl[i].rcnt));
    end
    a_halt = 1'b0; a_retire = 1'b0;
  endtask

  task automatic reset_a();
    a_reset = 1'b1; a_halt = 1'b0; a_retire = 1'b0;
    tick(); tick();
    a_reset = 1'b0;
    repeat (A_RC) tick();
  endtask

  initial begin
    int rc;
    logic r, h, t;
    tbl[0] = '{1'b1, 1'b0, 1'b0, 0, 0, 0};
    tbl[1] = '{1'b1, 1'b1, 1'b1, 0, 0, 0};
    tbl[2] = '{1'b0, 1'b0, 1'b0, 0, 0, 0};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 0, 0, 0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 1, 0, 0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1, 1, 1};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 1, 2, 2};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 1, 3, 2};
    tbl[8] = '{1'b0, 1'b1, 1'b1, 2, 4, 3};

    run_table("hold_seq");

    // halt at cycle_count 20, four drain cycles with retire held high
    reset_a();
    for (int i = 0; i < 20; i++) begin
      a_retire = (i < 10);
      tick();
    end
    chk("pre_halt", obs(0), expect_of(1, 20, 10));
    a_halt = 1'b1; a_retire = 1'b0;
    tick();
    chk("drain_entry", obs(0), expect_of(2, 21, 10));
    a_retire = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("drain_%0d", i), obs(0), expect_of(2, 22 + i, 11 + i));
    end
    a_halt = 1'b0;
    tick();
    chk("halted", obs(0), expect_of(3, 25, 14));
    for (int i = 0; i < 50; i++) begin
      a_retire = 1'($urandom_range(0, 1));
      a_halt = 1'($urandom_range(0, 1));
      tick();
      chk("halted_frozen", obs(0), expect_of(3, 25, 14));
    end

    // watchdog with no halt
    reset_a();
    rc = 0;
    for (int i = 0; i < 49; i++) begin
      a_retire = 1'($urandom_range(0, 1));
      rc += int'(a_retire);
      tick();
    end
    chk("pre_timeout", obs(0), expect_of(1, 49, rc));
    a_retire = 1'($urandom_range(0, 1));
    rc += int'(a_retire);
    tick();
    chk("timeout", obs(0), expect_of(4, 50, rc));
    for (int i = 0; i < 5; i++) begin
      a_retire = 1'b1; a_halt = 1'b1;
      tick();
      chk("timeout_frozen", obs(0), expect_of(4, 50, rc));
    end

    // reset in the middle of a drain, then full sequence again
    reset_a();
    repeat (27) tick();
    a_halt = 1'b1;
    tick();
    a_halt = 1'b0;
    tick(); tick();
    chk("mid_drain", obs(0), expect_of(2, 30, 0));
    a_reset = 1'b1;
    tick();
    chk("drain_reset", obs(0), expect_of(0, 0, 0));
    run_table("repeat_seq");

    // dut_b: halt on the watchdog cycle with no drain
    b_reset = 1'b1;
    tick(); tick();
    b_reset = 1'b0;
    tick();
    chk("b_run_start", obs(1), expect_of(1, 0, 0));
    repeat (49) tick();
    chk("b_last_cycle", obs(1), expect_of(1, 49, 0));
    b_halt = 1'b1;
    tick();
    b_halt = 1'b0;
    chk("b_halt_beats_watchdog", obs(1), expect_of(3, 50, 0));
    repeat (3) tick();
    chk("b_halted_sticky", obs(1), expect_of(3, 50, 0));

    // dut_c: narrow counters saturate
    c_reset = 1'b1;
    tick(); tick();
    c_reset = 1'b0;
    tick();
    chk("c_hold", obs(2), expect_of(0, 0, 0));
    tick();
    chk("c_run_start", obs(2), expect_of(1, 0, 0));
    c_retire = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (i == 14) chk("c_reach_max", obs(2), expect_of(1, 15, 15));
      if (i == 15) chk("c_no_wrap", obs(2), expect_of(1, 15, 15));
    end
    chk("c_saturated", obs(2), expect_of(1, 15, 15));
    c_retire = 1'b0;

    // randomized run of dut_a against the model
    a_reset = 1'b1; a_halt = 1'b0; a_retire = 1'b0;
    model_step(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4000; i++) begin
      r = ($urandom_range(0, 149) == 0);
      h = ($urandom_range(0, 29) == 0);
      t = 1'($urandom_range(0, 1));
      a_reset = r; a_halt = h; a_retire = t;
      model_step(r, h, t);
      tick();
      chk("random", obs(0), expect_of(m_state(), m_cyc, m_ret));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/run_controller.md
Name: run_controller

Overview:
- Parametrised run-control block that sits between the bench/board clock and reset and the processor `TopLevel`.
- Sequences the core reset for a programmable number of cycles, then lets the core run.
- Counts cycles and retired instructions.
- Detects the `syscall` halt, drains the pipeline and reports done. A cycle-budget watchdog reports timeout when no halt arrives.

Parameters:
- RESET_CYCLES, 1: cycles core_reset stays high after reset deasserts (>=1).
- MAX_CYCLES, 100000: run-cycle budget before timeout (>=2).
- DRAIN_CYCLES, 4: cycles the core keeps running after a halt request (0 allowed).
- CNT_W, 32: width of cycle_count and retire_count.

Ports:
- clock  in  1  system clock, all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- halt_req  in  1  one-cycle pulse from core: syscall reached writeback.
- retire  in  1  core retired one instruction this cycle.
- core_reset  out  1  reset to TopLevel.
- run  out  1  core is executing (RUN or DRAIN).
- done  out  1  sticky end-of-run flag.
- timeout  out  1  sticky, run ended by watchdog.
- cycle_count  out  CNT_W  cycles spent in RUN+DRAIN.
- retire_count  out  CNT_W  instructions retired in RUN+DRAIN.
- state  out  3  current FSM state (debug).

Behaviour:
- Single clock domain: clock. reset is synchronous and active-high. All outputs are registered.
- Values while reset=1:
  - state=HOLD, core_reset=1, run=0, done=0, timeout=0.
  - cycle_count=0, retire_count=0, internal hold/drain counters=0.
- State encoding: HOLD=0, RUN=1, DRAIN=2, HALTED=3, TIMEOUT=4.
- HOLD:
  - core_reset=1, and the hold counter increments each cycle.
  - On the cycle the counter reaches RESET_CYCLES-1 -> RUN. core_reset is low starting the next cycle.
  - Net effect: core_reset stays high for exactly RESET_CYCLES cycles after reset falls.
  - halt_req and retire are ignored in HOLD.
- RUN:
  - run=1. cycle_count increments every cycle. retire_count increments when retire=1.
  - Both counters saturate at all-ones and do not wrap.
  - halt_req=1 -> DRAIN, or straight to HALTED when DRAIN_CYCLES=0.
  - cycle_count==MAX_CYCLES-1 with no halt_req -> TIMEOUT.
  - halt_req and the timeout condition in the same cycle: halt wins -> DRAIN/HALTED, timeout stays 0.
- DRAIN:
  - run=1, counters keep counting, including retires.
  - The drain counter runs 0..DRAIN_CYCLES-1, then -> HALTED.
  - Further halt_req is ignored. The watchdog is not checked in DRAIN.
- HALTED: done=1, timeout=0, run=0. Counters frozen. Sticky until reset.
- TIMEOUT: done=1, timeout=1, run=0. Counters frozen. Sticky until reset.
- done and run are never both 1.
- core_reset is low in every state except HOLD.
- Reset asserted in any state, mid-run or mid-drain: next cycle is HOLD with all values cleared. The full reset sequence repeats after reset falls.
- retire and halt_req asserted in the same RUN cycle: the retire is counted.

Decomposition:
- Package run_ctrl_pkg holds:
  - state encoding constants (HOLD..TIMEOUT) and the 3-bit state width;
  - default values for RESET_CYCLES, MAX_CYCLES and DRAIN_CYCLES.
- Sub-module sat_counter (parameter W; ports clock, reset, clr, en, q): a saturating up-counter, instantiated twice for cycle_count and retire_count.
- The FSM, hold counter and drain counter stay in run_controller.

Test Plan:
- Hold reset 2 cycles, RESET_CYCLES=3 -> core_reset high exactly 3 cycles after reset falls. state goes 0->1, run rises on the 4th cycle.
- RUN with retire high 10 cycles, then halt_req pulse at cycle_count=20, DRAIN_CYCLES=4, retire held high through drain:
  - -> DRAIN for 4 cycles, then state=3, done=1, timeout=0;
  - cycle_count=25, retire_count=14; values frozen for the following 50 cycles.
- MAX_CYCLES=50, no halt_req -> state=4, done=1, timeout=1, cycle_count=50, run=0.
- MAX_CYCLES=50, halt_req on the cycle where cycle_count=49, DRAIN_CYCLES=0 -> state=3, timeout=0.
- Reset asserted in DRAIN at cycle 30 -> next cycle state=0, counters=0, core_reset=1; the full sequence repeats correctly.
- CNT_W=4, retire held high for 40 RUN cycles -> retire_count saturates at 15, no wrap.
